// File: rtl/adc_spi_capture.sv
// Sigma-delta ADC SPI reader (CPOL=1, CPHA=1, MSB first) feeding a sample FIFO.
// Optional saturating drop counter is built when ADC_CAPTURE_DROPCNT_EN is defined.
module adc_spi_capture #(
  parameter int DATA_WIDTH = 24,
  parameter int CLK_DIV    = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_a,
  input  logic                  enable,
  input  logic                  adc_drdy_n,
  input  logic                  adc_dout,
  output logic                  adc_cs_n,
  output logic                  adc_sclk,
  output logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_wr_en,
  input  logic                  fifo_full,
  output logic                  busy,
  output logic                  overrun,
  input  logic                  overrun_clr,
  output logic [7:0]            drop_count
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_WRITE = 3'd3,
    ST_REARM = 3'd4
  } state_t;

  localparam logic [CNT_WIDTH-1:0] DIV_LAST = CNT_WIDTH'(CLK_DIV - 1);
  localparam logic [CNT_WIDTH-1:0] BIT_LAST = CNT_WIDTH'(DATA_WIDTH);
  localparam logic [CNT_WIDTH-1:0] ONE      = CNT_WIDTH'(1);

  state_t                  state_q, state_d;
  logic                    drdy_meta_q, drdy_s_q, dout_meta_q, dout_s_q;
  logic [CNT_WIDTH-1:0]    div_cnt_q, div_cnt_d;
  logic [CNT_WIDTH-1:0]    bit_cnt_q, bit_cnt_d;
  logic                    sclk_q, sclk_d;
  logic                    cs_n_q, cs_n_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic [DATA_WIDTH-1:0]   fifo_data_q, fifo_data_d;
  logic                    fifo_wr_en_q, fifo_wr_en_d;
  logic                    overrun_q, overrun_d;
  logic                    div_done;
  logic                    drop_evt;

  // Both ADC lines are asynchronous; only the _s versions are used past here.
  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      drdy_meta_q <= 1'b1;
      drdy_s_q    <= 1'b1;
      dout_meta_q <= 1'b0;
      dout_s_q    <= 1'b0;
    end else begin
      drdy_meta_q <= adc_drdy_n;
      drdy_s_q    <= drdy_meta_q;
      dout_meta_q <= adc_dout;
      dout_s_q    <= dout_meta_q;
    end
  end

  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  assign div_done = (div_cnt_q == DIV_LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (enable && !drdy_s_q) state_d = ST_SETUP;
      ST_SETUP: if (div_done) state_d = ST_SHIFT;
      ST_SHIFT: if (div_done && sclk_q && (bit_cnt_q == BIT_LAST)) state_d = ST_WRITE;
      ST_WRITE: state_d = ST_REARM;
      ST_REARM: if (drdy_s_q) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FIFO push: fifo_wr_en is a one-cycle valid; it is only raised when
  // fifo_full (the inverse of ready) was low in WRITE, otherwise the word drops.
  always_comb begin
    div_cnt_d    = '0;
    sclk_d       = 1'b1;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    fifo_data_d  = fifo_data_q;
    fifo_wr_en_d = 1'b0;
    overrun_d    = overrun_q;
    cs_n_d       = !((state_d == ST_SETUP) || (state_d == ST_SHIFT));
    case (state_q)
      ST_SETUP: begin
        div_cnt_d = div_done ? '0 : div_cnt_q + ONE;
        sclk_d    = !div_done;
        bit_cnt_d = '0;
      end
      ST_SHIFT: begin
        div_cnt_d = div_done ? '0 : div_cnt_q + ONE;
        sclk_d    = div_done ? !sclk_q : sclk_q;
        // Sample on the edge that raises SCLK (trailing edge for CPHA=1).
        if (div_done && !sclk_q) begin
          shift_d   = {shift_q[DATA_WIDTH-2:0], dout_s_q};
          bit_cnt_d = bit_cnt_q + ONE;
        end
        if (state_d == ST_WRITE) sclk_d = 1'b1;
      end
      ST_WRITE: begin
        if (fifo_full) begin
          overrun_d = 1'b1;
        end else begin
          fifo_data_d  = shift_q;
          fifo_wr_en_d = 1'b1;
        end
      end
      default: ;
    endcase
    if (overrun_clr) overrun_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      div_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      sclk_q       <= 1'b1;
      cs_n_q       <= 1'b1;
      shift_q      <= '0;
      fifo_data_q  <= '0;
      fifo_wr_en_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      sclk_q       <= sclk_d;
      cs_n_q       <= cs_n_d;
      shift_q      <= shift_d;
      fifo_data_q  <= fifo_data_d;
      fifo_wr_en_q <= fifo_wr_en_d;
      overrun_q    <= overrun_d;
    end
  end

  assign drop_evt = (state_q == ST_WRITE) && fifo_full;

`ifdef ADC_CAPTURE_DROPCNT_EN
  logic [7:0] drop_count_q, drop_count_d;

  // Clear beats a same-cycle drop; that drop is intentionally not counted.
  always_comb begin
    drop_count_d = drop_count_q;
    if (overrun_clr)                          drop_count_d = 8'h00;
    else if (drop_evt && drop_count_q != 8'hFF) drop_count_d = drop_count_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) drop_count_q <= 8'h00;
    else       drop_count_q <= drop_count_d;
  end

  assign drop_count = drop_count_q;
`else
  logic drop_unused;
  assign drop_unused = drop_evt;
  assign drop_count  = 8'h00;
`endif

  assign adc_cs_n   = cs_n_q;
  assign adc_sclk   = sclk_q;
  assign fifo_data  = fifo_data_q;
  assign fifo_wr_en = fifo_wr_en_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_adc_spi_capture.sv
// Bench for adc_spi_capture: ADC shift-out models, write scoreboards and frame monitors
// for a CLK_DIV=4 instance and a CLK_DIV=2 instance.
module tb_adc_spi_capture;

  localparam int DW   = 24;
  localparam int LAT1 = 4 * (2 * DW + 1) + 1;
  localparam int LAT2 = 2 * (2 * DW + 1) + 1;
`ifdef ADC_CAPTURE_DROPCNT_EN
  localparam int EXP_DROPS = 3;
`else
  localparam int EXP_DROPS = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_a = 1'b1;

  logic          enable = 1'b0, drdy_n = 1'b1, dout = 1'b0, fifo_full = 1'b0, overrun_clr = 1'b0;
  logic          adc_cs_n, adc_sclk, fifo_wr_en, busy, overrun;
  logic [DW-1:0] fifo_data;
  logic [7:0]    drop_count;

  logic          enable2 = 1'b0, drdy_n2 = 1'b1, dout2 = 1'b0;
  logic          adc_cs_n2, adc_sclk2, fifo_wr_en2, busy2, overrun2;
  logic [DW-1:0] fifo_data2;
  logic [7:0]    drop_count2;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp2_q[$];
  logic [DW-1:0] adc_word = '0, adc_word2 = '0;
  int            bit_idx = 0, bit_idx2 = 0;
  int            n_checks = 0, n_errors = 0;
  int            frames1 = 0, frames2 = 0;

  adc_spi_capture #(.DATA_WIDTH(DW), .CLK_DIV(4), .CNT_WIDTH(8)) u_dut (
    .clk(clk), .rst_a(rst_a), .enable(enable), .adc_drdy_n(drdy_n), .adc_dout(dout),
    .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk), .fifo_data(fifo_data), .fifo_wr_en(fifo_wr_en),
    .fifo_full(fifo_full), .busy(busy), .overrun(overrun), .overrun_clr(overrun_clr),
    .drop_count(drop_count)
  );

  adc_spi_capture #(.DATA_WIDTH(DW), .CLK_DIV(2), .CNT_WIDTH(8)) u_dut2 (
    .clk(clk), .rst_a(rst_a), .enable(enable2), .adc_drdy_n(drdy_n2), .adc_dout(dout2),
    .adc_cs_n(adc_cs_n2), .adc_sclk(adc_sclk2), .fifo_data(fifo_data2), .fifo_wr_en(fifo_wr_en2),
    .fifo_full(1'b0), .busy(busy2), .overrun(overrun2), .overrun_clr(1'b0),
    .drop_count(drop_count2)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ADC models: MSB presented at CS fall, next bit after each SCLK rise.
  always @(negedge adc_cs_n) begin
    bit_idx = DW - 1;
    dout = adc_word[bit_idx];
  end
  always @(posedge adc_sclk) begin
    if (adc_cs_n === 1'b0 && bit_idx > 0) begin
      bit_idx--;
      dout = adc_word[bit_idx];
    end
  end
  always @(negedge adc_cs_n2) begin
    bit_idx2 = DW - 1;
    dout2 = adc_word2[bit_idx2];
  end
  always @(posedge adc_sclk2) begin
    if (adc_cs_n2 === 1'b0 && bit_idx2 > 0) begin
      bit_idx2--;
      dout2 = adc_word2[bit_idx2];
    end
  end

  // Monitor and scoreboard, instance 1
  logic cs_prev = 1'b1, sclk_prev = 1'b1, wr_prev = 1'b0;
  int   lat = 0, rises = 0;
  always @(negedge clk) begin
    if (rst_a) begin
      cs_prev = 1'b1; sclk_prev = 1'b1; wr_prev = 1'b0;
    end else begin
      if (!adc_cs_n && cs_prev) begin
        lat = 0; rises = 0; frames1++;
        check_eq("busy_at_cs_fall", busy, 1);
      end else begin
        lat++;
      end
      if (!adc_cs_n && adc_sclk && !sclk_prev) rises++;
      if (adc_cs_n && !cs_prev) check_eq("sclk_rises_in_cs", rises, DW);
      if (fifo_wr_en) begin
        check_eq("wr_en_single", wr_prev, 0);
        check_eq("wr_latency", lat, LAT1);
        if (exp_q.size() == 0) check_eq("wr_unexpected", exp_q.size(), 1);
        else                   check_eq("wr_data", fifo_data, exp_q.pop_front());
      end
      cs_prev = adc_cs_n; sclk_prev = adc_sclk; wr_prev = fifo_wr_en;
    end
  end

  // Monitor and scoreboard, instance 2 (also measures SCLK period)
  logic cs2_prev = 1'b1, sclk2_prev = 1'b1;
  int   lat2 = 0, rises2 = 0, cyc2 = 0, last_rise2 = 0;
  always @(negedge clk) begin
    cyc2++;
    if (rst_a) begin
      cs2_prev = 1'b1; sclk2_prev = 1'b1;
    end else begin
      if (!adc_cs_n2 && cs2_prev) begin
        lat2 = 0; rises2 = 0; frames2++;
      end else begin
        lat2++;
      end
      if (!adc_cs_n2 && adc_sclk2 && !sclk2_prev) begin
        if (rises2 > 0) check_eq("sclk2_period", cyc2 - last_rise2, 4);
        last_rise2 = cyc2;
        rises2++;
      end
      if (adc_cs_n2 && !cs2_prev) check_eq("sclk2_rises_in_cs", rises2, DW);
      if (fifo_wr_en2) begin
        check_eq("wr2_latency", lat2, LAT2);
        if (exp2_q.size() == 0) check_eq("wr2_unexpected", exp2_q.size(), 1);
        else                    check_eq("wr2_data", fifo_data2, exp2_q.pop_front());
      end
      cs2_prev = adc_cs_n2; sclk2_prev = adc_sclk2;
    end
  end

  // Driver tasks
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_cs(input int which, input logic level, input int budget, input string tag);
    int n = 0;
    while (((which == 1) ? adc_cs_n : adc_cs_n2) !== level && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, (n < budget), 1);
  endtask

  task automatic run_frame(input int which, input logic [DW-1:0] word, input bit expect_write);
    if (which == 1) begin
      adc_word = word;
      if (expect_write) exp_q.push_back(word);
      drdy_n = 1'b0;
    end else begin
      adc_word2 = word;
      if (expect_write) exp2_q.push_back(word);
      drdy_n2 = 1'b0;
    end
    wait_cs(which, 1'b0, 100, "cs_fall_timeout");
    wait_cs(which, 1'b1, 400, "cs_rise_timeout");
    wait_cycles(6);
    if (which == 1) drdy_n = 1'b1;
    else            drdy_n2 = 1'b1;
    wait_cycles(6);
  endtask

  initial begin
    int seen;
    logic [DW-1:0] w;
    wait_cycles(3);
    check_eq("rst_cs_n", adc_cs_n, 1);
    check_eq("rst_sclk", adc_sclk, 1);
    check_eq("rst_fifo_data", fifo_data, 0);
    check_eq("rst_wr_en", fifo_wr_en, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_overrun", overrun, 0);
    check_eq("rst_drop_count", drop_count, 0);
    rst_a = 1'b0;
    wait_cycles(3);

    // First frame; drdy_n stays low afterwards so no re-read may happen
    enable = 1'b1;
    adc_word = 24'hA5C3F1;
    exp_q.push_back(24'hA5C3F1);
    drdy_n = 1'b0;
    wait_cs(1, 1'b0, 100, "cs_fall_timeout");
    wait_cs(1, 1'b1, 400, "cs_rise_timeout");
    seen = frames1;
    wait_cycles(300);
    check_eq("no_reread_frames", frames1, seen);
    check_eq("data_held", fifo_data, 24'hA5C3F1);
    check_eq("busy_in_rearm", busy, 1);
    drdy_n = 1'b1;
    wait_cycles(3);
    run_frame(1, 24'h000001, 1);
    check_eq("busy_idle", busy, 0);

    // Three dropped frames with FIFO full
    fifo_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      w = DW'($urandom_range(0, 24'hFFFFFF));
      run_frame(1, w, 0);
    end
    fifo_full = 1'b0;
    check_eq("overrun_set", overrun, 1);
    check_eq("drop_count_3", drop_count, EXP_DROPS);
    check_eq("data_unchanged_on_drop", fifo_data, 24'h000001);
    overrun_clr = 1'b1;
    wait_cycles(1);
    overrun_clr = 1'b0;
    check_eq("overrun_cleared", overrun, 0);
    check_eq("drop_count_cleared", drop_count, 0);

    for (int i = 0; i < 2; i++) begin
      w = DW'($urandom_range(0, 24'hFFFFFF));
      run_frame(1, w, 1);
    end

    // enable removed mid-SHIFT: frame still writes, no further frames
    adc_word = 24'h123456;
    exp_q.push_back(24'h123456);
    drdy_n = 1'b0;
    wait_cs(1, 1'b0, 100, "cs_fall_timeout");
    wait_cycles(54);
    enable = 1'b0;
    wait_cs(1, 1'b1, 400, "cs_rise_timeout");
    wait_cycles(6);
    drdy_n = 1'b1;
    wait_cycles(6);
    drdy_n = 1'b0;
    seen = frames1;
    wait_cycles(300);
    check_eq("no_frame_when_disabled", frames1, seen);
    check_eq("data_after_disable", fifo_data, 24'h123456);

    // Reset 100 cycles into SHIFT, then a clean frame
    adc_word = 24'h5A5A5A;
    enable = 1'b1;
    wait_cs(1, 1'b0, 100, "cs_fall_timeout");
    wait_cycles(104);
    rst_a = 1'b1;
    #1;
    check_eq("midrst_cs_n", adc_cs_n, 1);
    check_eq("midrst_sclk", adc_sclk, 1);
    check_eq("midrst_wr_en", fifo_wr_en, 0);
    wait_cycles(3);
    adc_word = 24'h3C3C3C;
    exp_q.push_back(24'h3C3C3C);
    rst_a = 1'b0;
    wait_cs(1, 1'b0, 100, "cs_fall_timeout");
    wait_cs(1, 1'b1, 400, "cs_rise_timeout");
    wait_cycles(6);
    check_eq("data_after_rst", fifo_data, 24'h3C3C3C);
    drdy_n = 1'b1;
    wait_cycles(6);

    // CLK_DIV=2 instance
    enable2 = 1'b1;
    run_frame(2, 24'hFFFFFF, 1);
    run_frame(2, 24'h800000, 1);
    check_eq("dut2_data_last", fifo_data2, 24'h800000);

    wait_cycles(10);
    check_eq("queue1_empty", exp_q.size(), 0);
    check_eq("queue2_empty", exp2_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
